// File: rtl/mem_access_unit_if.sv
// Data-memory / MMIO bus between the load/store unit (master) and memory (slave).
// One request stays on the bus until bus_ready. Read data is valid with bus_ready.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_ready;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store executor: validates requests, drives the memory bus with steered lanes,
// extends load data, and holds the pipeline until the access retires or faults.
module mem_access_unit #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        rw_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              done,
   output logic              fault,
   output logic [1:0]        fault_code,
   mem_access_unit_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        type_q, type_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;
   logic [1:0]        code_q, code_d;
   logic [31:0]       load_q, load_d;

   logic        req, illegal, misaligned, accept;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] rd_shift;
   logic [31:0] ext_calc;

   assign req = mem_read | mem_write;

   // Only lb/lh/lw/lbu/lhu encodings exist; the unsigned forms are load-only.
   assign illegal = (mem_read & mem_write)
                  | (rw_type == 3'b011) | (rw_type == 3'b110) | (rw_type == 3'b111)
                  | (mem_write & rw_type[2]);

   assign misaligned = ((rw_type[1:0] == 2'b01) & addr[0])
                     | ((rw_type[1:0] == 2'b10) & (addr[1:0] != 2'b00));

   assign accept = (state_q == S_IDLE) & req & ~illegal & ~misaligned;
   assign stall  = accept | (state_q == S_BUS);

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (rw_type[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = wdata;
         end
      endcase
   end

   // Lane select uses the offset latched at request time, not the live address.
   always_comb begin
      rd_shift = bus.bus_rdata >> {off_q, 3'b000};
      case (type_q)
         3'b000:  ext_calc = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ext_calc = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  ext_calc = {24'd0, rd_shift[7:0]};
         3'b101:  ext_calc = {16'd0, rd_shift[15:0]};
         default: ext_calc = bus.bus_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      type_d      = type_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      code_d      = code_q;
      load_d      = load_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (illegal) begin
                  fault_d = 1'b1;
                  code_d  = 2'b10;
               end else if (misaligned) begin
                  fault_d = 1'b1;
                  code_d  = 2'b01;
               end else begin
                  bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  bus_be_d    = be_calc;
                  bus_wdata_d = wdata_calc;
                  bus_we_d    = mem_write;
                  off_d       = addr[1:0];
                  type_d      = rw_type;
                  bus_req_d   = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_BUS;
               end
            end
         end
         S_BUS: begin
            if (bus.bus_ready) begin
               bus_req_d = 1'b0;
               done_d    = 1'b1;
               if (!bus_we_q) load_d = ext_calc;
               state_d   = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               bus_req_d = 1'b0;
               fault_d   = 1'b1;
               code_d    = 2'b11;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         off_q       <= 2'b00;
         type_q      <= 3'b000;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'd0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         code_q      <= 2'b00;
         load_q      <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         type_q      <= type_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
         code_q      <= code_d;
         load_q      <= load_d;
      end
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_be    = bus_be_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign done          = done_q;
   assign fault         = fault_q;
   assign fault_code    = code_q;
   assign load_data     = load_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random load/store traffic against a behavioural model of the
// load/store rules; the bench plays the memory side with a chosen wait count.
module tb_mem_access_unit;
   localparam int TIMEOUT = 4;
   localparam int ADDR_W  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [2:0]        rw_type = 3'b000;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       wdata = 32'd0;
   logic              stall;
   logic [31:0]       load_data;
   logic              done;
   logic              fault;
   logic [1:0]        fault_code;

   int tests = 0;
   int failed = 0;
   logic [31:0] ld_model = 32'd0;

   mem_access_unit_if #(.ADDR_W(ADDR_W)) bus_if ();

   mem_access_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .rw_type(rw_type), .addr(addr), .wdata(wdata), .stall(stall),
      .load_data(load_data), .done(done), .fault(fault), .fault_code(fault_code),
      .bus(bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input logic [2:0] t, input logic [1:0] off);
      if (t[1:0] == 2'b00) return 4'(1 << off);
      if (t[1:0] == 2'b01) return (off >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] t, input logic [31:0] w);
      if (t[1:0] == 2'b00) return (w & 32'hFF) * 32'h01010101;
      if (t[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] t, input logic [1:0] off,
                                        input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * off);
      case (t)
         3'b000:  return ((v & 32'hFF) >= 128) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
         3'b001:  return ((v & 32'hFFFF) >= 32768) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
         3'b100:  return v & 32'hFF;
         3'b101:  return v & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   // Entered and left at a falling edge with the unit expected idle.
   task automatic access(input logic mr, input logic mw, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int wait_n, input logic [31:0] rd);
      logic bad_type, misal, ok;
      int   req_cycles;
      bad_type = (mr && mw) || t == 3'b011 || t == 3'b110 || t == 3'b111 || (mw && t[2]);
      misal    = (t[1:0] == 2'b01 && a[0]) || (t[1:0] == 2'b10 && a[1:0] != 2'b00);
      mem_read = mr; mem_write = mw; rw_type = t; addr = a; wdata = wd;
      #1;
      chk("stall_req", stall, !(bad_type || misal));
      @(posedge clk); @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      if (bad_type || misal) begin
         chk("fault_pulse", fault, 1);
         chk("fault_code", fault_code, bad_type ? 2'b10 : 2'b01);
         chk("no_bus_req", bus_if.bus_req, 0);
         chk("stall_fault", stall, 0);
         $display("[TB] txn t=%0d a=%h rd=%0d wr=%0d -> fault %0d", t, a, mr, mw, fault_code);
         @(negedge clk);
         chk("fault_clear", fault, 0);
         return;
      end
      ok = 1'b0;
      req_cycles = 0;
      for (int i = 0; i < TIMEOUT && !ok; i++) begin
         chk("bus_req", bus_if.bus_req, 1);
         chk("bus_addr", bus_if.bus_addr, a & 32'hFFFFFFFC);
         chk("bus_be", bus_if.bus_be, m_be(t, a[1:0]));
         chk("bus_we", bus_if.bus_we, mw);
         if (mw) chk("bus_wdata", bus_if.bus_wdata, m_wd(t, wd));
         chk("stall_bus", stall, 1);
         req_cycles++;
         bus_if.bus_ready = (i == wait_n);
         bus_if.bus_rdata = (i == wait_n) ? rd : $urandom;
         @(posedge clk); @(negedge clk);
         ok = bus_if.bus_ready;
         bus_if.bus_ready = 1'b0;
      end
      chk("bus_req_drop", bus_if.bus_req, 0);
      chk("stall_after", stall, 0);
      if (ok) begin
         if (!mw) ld_model = m_ld(t, a[1:0], rd);
         chk("done_pulse", done, 1);
         chk("no_fault", fault, 0);
         chk("load_data", load_data, ld_model);
         $display("[TB] txn t=%0d a=%h wr=%0d wait=%0d -> done load_data=%h", t, a, mw, wait_n, load_data);
         @(negedge clk);
         chk("done_clear", done, 0);
      end else begin
         chk("timeout_cycles", req_cycles, TIMEOUT);
         chk("timeout_fault", fault, 1);
         chk("timeout_code", fault_code, 2'b11);
         chk("timeout_no_done", done, 0);
         $display("[TB] txn t=%0d a=%h wr=%0d wait=%0d -> timeout", t, a, mw, wait_n);
         @(negedge clk);
         chk("timeout_clear", fault, 0);
         chk("timeout_no_late_done", done, 0);
      end
   endtask

   initial begin
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_bus_req", bus_if.bus_req, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_bus_be", bus_if.bus_be, 0);
      rst_n = 1'b1;
      @(negedge clk);

      access(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF);
      access(1, 0, 3'b000, 32'h203, 0, 0, 32'h80123456);
      access(1, 0, 3'b100, 32'h203, 0, 0, 32'h80123456);
      access(1, 0, 3'b101, 32'h202, 0, 0, 32'hFFEE1234);
      access(0, 1, 3'b001, 32'h12, 32'h0000ABCD, 1, 0);
      access(0, 1, 3'b000, 32'h11, 32'h0000005A, 0, 0);
      access(1, 0, 3'b010, 32'h102, 0, 0, 0);
      access(0, 1, 3'b100, 32'h40, 32'h11, 0, 0);
      access(1, 1, 3'b010, 32'h40, 32'h11, 0, 0);
      access(1, 0, 3'b010, 32'h300, 0, 99, 32'h12345678);
      access(1, 0, 3'b001, 32'h302, 0, TIMEOUT - 1, 32'h8001CAFE);

      // Abort in the middle of a bus wait.
      mem_read = 1'b1; rw_type = 3'b010; addr = 32'h400;
      @(posedge clk); @(negedge clk);
      mem_read = 1'b0;
      chk("pre_rst_bus_req", bus_if.bus_req, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_req", bus_if.bus_req, 0);
      chk("mid_rst_load_data", load_data, 0);
      chk("mid_rst_bus_addr", bus_if.bus_addr, 0);
      chk("mid_rst_stall", stall, 0);
      ld_model = 32'd0;
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      access(1, 0, 3'b010, 32'h404, 0, 0, 32'hA5A5F00D);

      for (int n = 0; n < 60; n++) begin
         int r;
         logic mr, mw;
         r = $urandom_range(0, 9);
         mr = (r == 0) || (r < 6);
         mw = (r == 0) || (r >= 6);
         access(mr, mw, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, TIMEOUT + 1), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store executor: consumes the main-decoder control outputs (MemRead, MemWrite, RW_type) plus ALU address and rs2 data, and drives the data-memory/MMIO bus as initiator.
- Handles byte-lane steering, byte enables, load sign/zero extension, misalignment detection, and a bus-ready handshake with timeout.
- Holds the core pipeline via `stall` until the access retires.

Parameters:
TIMEOUT, 16, max cycles waiting for bus_ready before abort (>=1)
ADDR_W, 32, address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  load request (MemRead)
mem_write  in  1  store request (MemWrite)
rw_type  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  ADDR_W  effective address from ALU
wdata  in  32  store data (rs2)
stall  out  1  hold pipeline (combinational)
load_data  out  32  extended load result, valid when done=1
done  out  1  one-cycle pulse: access retired OK
fault  out  1  one-cycle pulse: misaligned/illegal/timeout
fault_code  out  2  01 misaligned, 10 illegal rw_type or rd&wr, 11 timeout
bus_req  out  1  bus request
bus_we  out  1  1=write
bus_addr  out  ADDR_W  word-aligned address (addr[1:0]=00)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-steered write data
bus_ready  in  1  bus accepts/completes this cycle
bus_rdata  in  32  read data, valid with bus_ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bus_req, bus_we, done, fault=0; fault_code, bus_addr, bus_be, bus_wdata, load_data=0; timeout counter=0. Deassertion takes effect on next clk edge.
- FSM states: IDLE, BUS, RESP.
- IDLE with mem_read|mem_write=1 → check request:
  - Illegal: both mem_read and mem_write; rw_type in {011,110,111}; or store with rw_type 100/101 → fault=1, code 10, for next cycle. Stay IDLE, no bus activity.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00 → fault=1, code 01, next cycle. Stay IDLE.
  - Otherwise: register bus_addr={addr[ADDR_W-1:2],2'b00}, bus_be, bus_wdata, bus_we, offset, and type; set bus_req=1; go to BUS.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111.
- Store steering: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- BUS state:
  - bus_req held at 1; all bus outputs held stable until bus_ready.
  - On bus_ready: bus_req←0; for loads, capture bus_rdata; go to RESP.
  - Counter increments each BUS cycle without ready. If count reaches TIMEOUT-1 and bus_ready=0: bus_req←0, fault=1, code 11, go to IDLE.
  - bus_ready on the final allowed cycle counts as success.
- RESP state (one cycle): done=1; load_data valid; go to IDLE.
  - Load extension: select lane by stored offset; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
  - load_data holds its value until the next load retires.
  - Stores also pass through RESP (done=1; load_data unchanged).
- stall = (IDLE & legal aligned request) | BUS. stall=0 in RESP, so the pipeline advances the cycle done=1. stall=0 on the fault path.
- Minimum latency: request cycle → BUS (bus_req) → ready seen → RESP/done. 3 cycles with zero-wait bus_ready.
- New requests are sampled only in IDLE. Control inputs are ignored in BUS and RESP.
- Reset mid-access: bus_req drops immediately (async); the transaction is abandoned and no done/fault is issued.
- bus_ready while IDLE or RESP is ignored.

Test Plan:
1. lw addr=0x100, bus_ready on first BUS cycle, bus_rdata=0xDEADBEEF → bus_be=1111, bus_addr=0x100; done after 3 cycles; load_data=0xDEADBEEF; stall high 2 cycles.
2. lb addr=0x203, bus_rdata=0x80xxxxxx → bus_be=1000; load_data=0xFFFFFF80. Repeat as lbu → 0x00000080. lhu addr=0x202 with rdata=0xFFEE1234 → load_data=0x0000FFEE.
3. sh addr=0x12, wdata=0x0000ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x10. Then sb addr=0x11, wdata=0x5A → be=0010, wdata=0x5A5A5A5A.
4. lw addr=0x102 → fault=1, code 01, no bus_req, stall=0. Store with rw_type=100 → code 10. mem_read&mem_write → code 10.
5. TIMEOUT=4, bus_ready never asserted → bus_req high exactly 4 cycles, then fault code 11, state IDLE, no done. Variant with ready on the 4th cycle → done, no fault.
6. rst_n pulled low during BUS with bus_req=1 → bus_req=0 immediately; all outputs at reset values; a new lw after release completes normally.
